sc_scbc_ftc_mc: RTL

//  Multi-channel frame timing controller with its register bank, in the ULPICLK domain of SCBC.
//  Per channel: down-counts a programmable frame interval on FM_TICK, emits a start-of-frame pulse,

---
 rtl/sc_scbc_ftc_mc.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sc_scbc_ftc_mc.sv
// Multi-channel frame timing controller and register bank: per-channel interval down-counter, SOF pulse, frame number, sticky status/IRQ.
// Latency: RDAT, FM_SOF and FM_IRQ are registered (1 cycle); no backpressure, register accesses always complete in one cycle.
module sc_scbc_ftc_mc #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 16,
    parameter int FN_W       = 11
) (
    input  logic                   ULPICLK,
    input  logic                   ULPIRST,
    input  logic                   WENB,
    input  logic [ADDR_WIDTH-1:0]  WADR,
    input  logic [31:0]            WDAT,
    input  logic [3:0]             WBEN,
    input  logic                   RENB,
    input  logic [ADDR_WIDTH-1:0]  RADR,
    output logic [31:0]            RDAT,
    input  logic                   FM_TICK,
    output logic [NUM_CH-1:0]      FM_SOF,
    output logic [NUM_CH*FN_W-1:0] FM_NUMBER,
    output logic                   FM_IRQ
);

    logic [CNT_W-1:0]  fmi_q [NUM_CH];
    logic [CNT_W-1:0]  fmi_d [NUM_CH];
    logic [CNT_W-1:0]  rem_q [NUM_CH];
    logic [CNT_W-1:0]  rem_d [NUM_CH];
    logic [FN_W-1:0]   num_q [NUM_CH];
    logic [FN_W-1:0]   num_d [NUM_CH];
    logic [1:0]        sts_q [NUM_CH];
    logic [1:0]        sts_d [NUM_CH];
    logic [1:0]        ien_q [NUM_CH];
    logic [1:0]        ien_d [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d, rtog_q, rtog_d, mode_q, mode_d, sof_q, sof_d;
    logic [NUM_CH-1:0] wsel;
    logic              irq_q, irq_d;
    logic [31:0]       rdat_q, rdat_d, rd_val;
    logic [15:0]       wmask;
    logic              wr_ok, rd_ok, sw_num;
    logic              addr_lsb_unused;

    assign wmask = {{8{WBEN[1]}}, {8{WBEN[0]}}};
    assign wr_ok = WENB && (WADR[ADDR_WIDTH-1:8] == '0);
    assign rd_ok = (RADR[ADDR_WIDTH-1:8] == '0);
    assign addr_lsb_unused = ^{WADR[1:0], RADR[1:0], WDAT, wmask};

    always_comb begin
        wsel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wsel[c] = wr_ok && (WADR[7:4] == 4'(c));
        end
    end

    always_comb begin
        irq_d  = 1'b0;
        sw_num = 1'b0;
        en_d   = en_q;
        rtog_d = rtog_q;
        mode_d = mode_q;
        sof_d  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            fmi_d[c] = fmi_q[c];
            rem_d[c] = rem_q[c];
            num_d[c] = num_q[c];
            sts_d[c] = sts_q[c];
            ien_d[c] = ien_q[c];
            if (wsel[c]) begin
                case (WADR[3:2])
                    2'd0: fmi_d[c] = (fmi_q[c] & ~wmask[CNT_W-1:0]) | (WDAT[CNT_W-1:0] & wmask[CNT_W-1:0]);
                    2'd1: if (WBEN[3]) en_d[c] = WDAT[31];
                    2'd2: begin
                        if (WBEN[3]) mode_d[c] = WDAT[31];
                        num_d[c] = (num_q[c] & ~wmask[FN_W-1:0]) | (WDAT[FN_W-1:0] & wmask[FN_W-1:0]);
                    end
                    default: begin
                        if (WBEN[0]) sts_d[c] = sts_q[c] & ~WDAT[1:0];
                        if (WBEN[2]) ien_d[c] = WDAT[17:16];
                    end
                endcase
            end
            sw_num = wsel[c] && (WADR[3:2] == 2'd2) && (|wmask[FN_W-1:0]);
            // Status sets are applied after the W1C clear so a same-cycle hw set survives.
            if (!en_d[c]) begin
                rem_d[c] = '0;
            end else if (!en_q[c]) begin
                rem_d[c] = fmi_q[c];
            end else if (FM_TICK) begin
                if (rem_q[c] == '0) begin
                    rem_d[c]    = fmi_q[c];
                    sof_d[c]    = 1'b1;
                    rtog_d[c]   = ~rtog_q[c];
                    sts_d[c][0] = 1'b1;
                    if (!mode_q[c] && !sw_num) begin
                        num_d[c] = num_q[c] + 1'b1;
                        if (&num_q[c]) sts_d[c][1] = 1'b1;
                    end
                end else begin
                    rem_d[c] = rem_q[c] - 1'b1;
                end
            end
            irq_d = irq_d | (|(sts_q[c] & ien_q[c]));
        end
    end

    always_comb begin
        rd_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ok && (RADR[7:4] == 4'(c))) begin
                case (RADR[3:2])
                    2'd0: rd_val[CNT_W-1:0] = fmi_q[c];
                    2'd1: begin
                        rd_val[31]          = en_q[c];
                        rd_val[16]          = rtog_q[c];
                        rd_val[CNT_W-1:0]   = rem_q[c];
                    end
                    2'd2: begin
                        rd_val[31]          = mode_q[c];
                        rd_val[FN_W-1:0]    = num_q[c];
                    end
                    default: begin
                        rd_val[17:16]       = ien_q[c];
                        rd_val[1:0]         = sts_q[c];
                    end
                endcase
            end
        end
        rdat_d = RENB ? rd_val : rdat_q;
    end

    always_ff @(posedge ULPICLK) begin
        if (ULPIRST) begin
            en_q   <= '0;
            rtog_q <= '0;
            mode_q <= '0;
            sof_q  <= '0;
            irq_q  <= 1'b0;
            rdat_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                fmi_q[c] <= '0;
                rem_q[c] <= '0;
                num_q[c] <= '0;
                sts_q[c] <= '0;
                ien_q[c] <= '0;
            end
        end else begin
            en_q   <= en_d;
            rtog_q <= rtog_d;
            mode_q <= mode_d;
            sof_q  <= sof_d;
            irq_q  <= irq_d;
            rdat_q <= rdat_d;
            for (int c = 0; c < NUM_CH; c++) begin
                fmi_q[c] <= fmi_d[c];
                rem_q[c] <= rem_d[c];
                num_q[c] <= num_d[c];
                sts_q[c] <= sts_d[c];
                ien_q[c] <= ien_d[c];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_num
        assign FM_NUMBER[g*FN_W +: FN_W] = num_q[g];
    end

    assign FM_SOF = sof_q;
    assign FM_IRQ = irq_q;
    assign RDAT   = rdat_q;

endmodule
